regfile_write_port: RTL

REGFILE_WRITE_PORT -- requirements
Module: regfile_write_port

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_write_port_addr_decoder.sv | 15 +
 rtl/regfile_write_port.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared FSM encoding and default geometry for the register-file write port.
package regfile_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        CLEAR = 1'b1
    } state_e;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SIZE  = 5;

endpackage

// File: rtl/regfile_write_port_addr_decoder.sv
// addr_decoder: maps a SIZE-bit address plus enable to a 2**SIZE one-hot vector.
module addr_decoder #(
    parameter int SIZE = 5
) (
    input  logic [SIZE-1:0]      addr,
    input  logic                 en,
    output logic [2**SIZE-1:0]   onehot
);

    always_comb begin
        onehot       = '0;
        onehot[addr] = en;
    end

endmodule

// File: rtl/regfile_write_port.sv
// regfile_write_port: 32-entry register file write port with a one-register-per-cycle clear sweep.
// Define REG_ZERO_LOCK_EN to hard-wire q0 to zero (writes to address 0 still report wr_done).
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SIZE  = DEF_SIZE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [SIZE-1:0]  wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clr_req,
    output logic             busy,
    output logic             wr_done,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [WIDTH-1:0] q8,
    output logic [WIDTH-1:0] q9,
    output logic [WIDTH-1:0] q10,
    output logic [WIDTH-1:0] q11,
    output logic [WIDTH-1:0] q12,
    output logic [WIDTH-1:0] q13,
    output logic [WIDTH-1:0] q14,
    output logic [WIDTH-1:0] q15,
    output logic [WIDTH-1:0] q16,
    output logic [WIDTH-1:0] q17,
    output logic [WIDTH-1:0] q18,
    output logic [WIDTH-1:0] q19,
    output logic [WIDTH-1:0] q20,
    output logic [WIDTH-1:0] q21,
    output logic [WIDTH-1:0] q22,
    output logic [WIDTH-1:0] q23,
    output logic [WIDTH-1:0] q24,
    output logic [WIDTH-1:0] q25,
    output logic [WIDTH-1:0] q26,
    output logic [WIDTH-1:0] q27,
    output logic [WIDTH-1:0] q28,
    output logic [WIDTH-1:0] q29,
    output logic [WIDTH-1:0] q30,
    output logic [WIDTH-1:0] q31
);

    localparam int NREG = 2**SIZE;

    state_e           state_q, state_d;
    logic [SIZE-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic             wr_done_q, wr_done_d;
    logic             accept;
    logic [NREG-1:0]  wr_en;

    assign wr_ready = state_q == RUN;
    assign busy     = state_q == CLEAR;
    assign wr_done  = wr_done_q;
    assign accept   = wr_valid && wr_ready;

    addr_decoder #(.SIZE(SIZE)) u_addr_decoder (
        .addr   (wr_addr),
        .en     (accept),
        .onehot (wr_en)
    );

    // The write is applied before the sweep so a same-edge write+clear is later zeroed.
    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        regs_d    = regs_q;
        wr_done_d = accept;
        for (int i = 0; i < NREG; i++)
            if (wr_en[i]) regs_d[i] = wr_data;
        if (state_q == RUN) begin
            if (clr_req) state_d = CLEAR;
        end else begin
            regs_d[cnt_q] = '0;
            cnt_d         = cnt_q + 1'b1;
            if (&cnt_q) state_d = RUN;
        end
`ifdef REG_ZERO_LOCK_EN
        regs_d[0] = '0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= RUN;
            cnt_q     <= '0;
            wr_done_q <= 1'b0;
            regs_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wr_done_q <= wr_done_d;
            regs_q    <= regs_d;
        end
    end

    assign q0  = regs_q[0];
    assign q1  = regs_q[1];
    assign q2  = regs_q[2];
    assign q3  = regs_q[3];
    assign q4  = regs_q[4];
    assign q5  = regs_q[5];
    assign q6  = regs_q[6];
    assign q7  = regs_q[7];
    assign q8  = regs_q[8];
    assign q9  = regs_q[9];
    assign q10 = regs_q[10];
    assign q11 = regs_q[11];
    assign q12 = regs_q[12];
    assign q13 = regs_q[13];
    assign q14 = regs_q[14];
    assign q15 = regs_q[15];
    assign q16 = regs_q[16];
    assign q17 = regs_q[17];
    assign q18 = regs_q[18];
    assign q19 = regs_q[19];
    assign q20 = regs_q[20];
    assign q21 = regs_q[21];
    assign q22 = regs_q[22];
    assign q23 = regs_q[23];
    assign q24 = regs_q[24];
    assign q25 = regs_q[25];
    assign q26 = regs_q[26];
    assign q27 = regs_q[27];
    assign q28 = regs_q[28];
    assign q29 = regs_q[29];
    assign q30 = regs_q[30];
    assign q31 = regs_q[31];

endmodule
